muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per clock.
module muldiv_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         kill,
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] ONES = {N{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic [2*N-1:0]  acc_q, acc_d;
   logic [N:0]      rem_q, rem_d;
   logic [N-1:0]    oth_q, oth_d;
   logic            negq_q, negq_d;
   logic            negr_q, negr_d;
   logic [N-1:0]    res_q, res_d;

   logic            a_sgn, b_sgn;
   logic            sa, sb;
   logic [N-1:0]    abs_a, abs_b;
   logic            is_div, div0, ovf, fast;
   logic [N-1:0]    fast_res;

   logic [N:0]      mul_sum;
   logic [2*N-1:0]  mul_nxt, prod;
   logic [N+1:0]    div_sh, div_diff;
   logic            div_ge;
   logic [N:0]      rem_nxt;
   logic [N-1:0]    quo_nxt, quo_f, rem_f;
   logic [N-1:0]    calc_res;

   // Decode operand signedness, magnitudes and fast-path cases at accept
   always_comb begin
      a_sgn = (op == 3'b001) || (op == 3'b010) ||
              (op == 3'b100) || (op == 3'b110);
      b_sgn = (op == 3'b001) || (op == 3'b100) ||
              (op == 3'b110);
      sa    = a_sgn & a[N-1];
      sb    = b_sgn & b[N-1];
      abs_a = sa ? (~a + 1'b1) : a;
      abs_b = sb ? (~b + 1'b1) : b;
      is_div = op[2];
      div0  = is_div && (b == '0);
      ovf   = is_div && !op[0] && (a == SMIN) && (b == ONES);
      fast  = div0 || ovf;
      if (div0) begin
         fast_res = op[1] ? a : ONES;
      end else begin
         fast_res = op[1] ? '0 : SMIN;
      end
   end

   // One shift-add or restore step, plus sign fix-up of the final value
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*N-1:N]} +
                 (acc_q[0] ? {1'b0, oth_q} : '0);
      mul_nxt  = {mul_sum, acc_q[N-1:1]};
      div_sh   = {rem_q, acc_q[N-1]};
      div_diff = div_sh - {2'b00, oth_q};
      div_ge   = !div_diff[N+1];
      rem_nxt  = div_ge ? div_diff[N:0] : div_sh[N:0];
      quo_nxt  = {acc_q[N-2:0], div_ge};
      prod     = negq_q ? (~mul_nxt + 1'b1) : mul_nxt;
      quo_f    = negq_q ? (~quo_nxt + 1'b1) : quo_nxt;
      rem_f    = negr_q ? (~rem_nxt[N-1:0] + 1'b1)
                        : rem_nxt[N-1:0];
      if (op_q[2]) begin
         calc_res = op_q[1] ? rem_f : quo_f;
      end else if (op_q[1:0] == 2'b00) begin
         calc_res = prod[N-1:0];
      end else begin
         calc_res = prod[2*N-1:N];
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      oth_d   = oth_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      res_d   = res_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !kill) begin
               op_d   = op;
               negq_d = sa ^ sb;
               negr_d = sa;
               cnt_d  = '0;
               rem_d  = '0;
               if (fast) begin
                  res_d   = fast_res;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
                  if (is_div) begin
                     acc_d = {{N{1'b0}}, abs_a};
                     oth_d = abs_b;
                  end else begin
                     acc_d = {{N{1'b0}}, abs_b};
                     oth_d = abs_a;
                  end
               end
            end
         end
         S_CALC: begin
            if (kill) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (op_q[2]) begin
                  acc_d = {{N{1'b0}}, quo_nxt};
                  rem_d = rem_nxt;
               end else begin
                  acc_d = mul_nxt;
               end
               if (cnt_q == LAST) begin
                  state_d = S_DONE;
                  res_d   = calc_res;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         oth_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         oth_q   <= oth_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         res_q   <= res_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE) && !kill;
   assign result = res_q;

endmodule
